code_byte_writer: RTL and testbench

- Write-side counterpart of the byte-fetch path. It accepts a stream of generated code bytes, such as JIT-emitted ARM instruction bytes, over a valid/ready handshake.
- Bytes are packed little-endian into 32-bit words, and each completed word is written to word-addressed memory through the same start/ready request interface the memory models use.
- An explicit flush writes a partially filled word padded with PAD_BYTE, so emitted code can be committed before execution.

---
 rtl/code_byte_writer.sv | 177 +++++++++++++++++
 tb/tb_code_byte_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_byte_writer.sv
// Packs a stream of code bytes little-endian into 32-bit words and writes each
// completed (or flushed, padded) word to word-addressed memory via start/ready.
`timescale 1ns/1ps
module code_byte_writer #(
  parameter int unsigned RAM_SIZE      = 256,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter logic [7:0]  PAD_BYTE      = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     flush_done,
  input  logic                     addr_load,
  input  logic [ADDRESS_WIDTH-1:0] addr_load_value,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [31:0]              mem_data_in,
  output logic                     mem_rwn,
  output logic                     mem_start,
  input  logic                     mem_ready,
  output logic [ADDRESS_WIDTH-1:0] word_ptr,
  output logic                     busy
);

  if ((RAM_SIZE == 32'd0) || (ADDRESS_WIDTH == 32'd0)) begin : g_bad_params
    $error("code_byte_writer: RAM_SIZE and ADDRESS_WIDTH must be non-zero");
  end

  typedef enum logic [0:0] {ST_FILL = 1'b0, ST_WRITE = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [31:0]              pack_q, pack_d;
  logic                     pend_q, pend_d;
  logic [ADDRESS_WIDTH-1:0] word_ptr_q, word_ptr_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [31:0]              mem_data_q, mem_data_d;
  logic                     mem_start_q, mem_start_d;
  logic                     mem_rwn_q, mem_rwn_d;
  logic                     flush_done_q, flush_done_d;
  logic                     busy_q, busy_d;

  logic [2:0]               cnt_new_s;
  logic [31:0]              fill_word_s;
  logic [31:0]              pad_word_s;
  logic                     write_now_s;

  // Ready is the only combinational output: addr_load steals the cycle from the byte stream.
  assign in_ready = (state_q == ST_FILL) && !addr_load;

  // Next-state and registered-output computation for the FILL/WRITE machine.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pack_d        = pack_q;
    pend_d        = pend_q;
    word_ptr_d    = word_ptr_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_start_d   = mem_start_q;
    mem_rwn_d     = mem_rwn_q;
    busy_d        = busy_q;
    flush_done_d  = 1'b0;
    write_now_s   = 1'b0;

    cnt_new_s   = cnt_q + {2'b00, in_valid};
    fill_word_s = pack_q;
    if (in_valid) begin
      fill_word_s[{cnt_q[1:0], 3'b000} +: 8] = in_byte;
    end else begin
      fill_word_s = pack_q;
    end
    pad_word_s = fill_word_s;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) >= cnt_new_s) begin
        pad_word_s[i*8 +: 8] = PAD_BYTE;
      end else begin
        pad_word_s[i*8 +: 8] = fill_word_s[i*8 +: 8];
      end
    end

    case (state_q)
      ST_FILL: begin
        if (addr_load) begin
          word_ptr_d = addr_load_value;
          cnt_d      = 3'd0;
          pack_d     = 32'd0;
        end else if (cnt_new_s == 3'd4) begin
          write_now_s = 1'b1;
          mem_data_d  = fill_word_s;
          pend_d      = flush;
        end else if (flush && (cnt_new_s != 3'd0)) begin
          write_now_s = 1'b1;
          mem_data_d  = pad_word_s;
          pend_d      = 1'b1;
        end else if (flush) begin
          flush_done_d = 1'b1;
        end else begin
          cnt_d  = cnt_new_s;
          pack_d = fill_word_s;
        end
        if (write_now_s) begin
          state_d       = ST_WRITE;
          cnt_d         = cnt_new_s;
          pack_d        = mem_data_d;
          mem_address_d = word_ptr_q;
          mem_start_d   = 1'b1;
          mem_rwn_d     = 1'b0;
          busy_d        = 1'b1;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          state_d      = ST_FILL;
          word_ptr_d   = word_ptr_q + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
          cnt_d        = 3'd0;
          pack_d       = 32'd0;
          mem_start_d  = 1'b0;
          mem_rwn_d    = 1'b1;
          busy_d       = 1'b0;
          flush_done_d = pend_q;
          pend_d       = 1'b0;
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d     = ST_FILL;
        mem_start_d = 1'b0;
        mem_rwn_d   = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FILL;
      cnt_q         <= 3'd0;
      pack_q        <= 32'd0;
      pend_q        <= 1'b0;
      word_ptr_q    <= '0;
      mem_address_q <= '0;
      mem_data_q    <= 32'd0;
      mem_start_q   <= 1'b0;
      mem_rwn_q     <= 1'b1;
      flush_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pack_q        <= pack_d;
      pend_q        <= pend_d;
      word_ptr_q    <= word_ptr_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_start_q   <= mem_start_d;
      mem_rwn_q     <= mem_rwn_d;
      flush_done_q  <= flush_done_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_q;
  assign mem_start   = mem_start_q;
  assign mem_rwn     = mem_rwn_q;
  assign flush_done  = flush_done_q;
  assign word_ptr    = word_ptr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_code_byte_writer.sv
// Randomized bench for code_byte_writer against a byte-queue reference model,
// plus directed sequences pinned with hand-computed literal values.
`timescale 1ns/1ps
module tb_code_byte_writer;
  localparam int unsigned AW = 8;
  localparam logic [7:0] PAD = 8'h00;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic          flush_done;
  logic          addr_load;
  logic [AW-1:0] addr_load_value;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_in;
  logic          mem_rwn;
  logic          mem_start;
  logic          mem_ready;
  logic [AW-1:0] word_ptr;
  logic          busy;

  always #5 clk = ~clk;

  code_byte_writer #(.RAM_SIZE(256), .ADDRESS_WIDTH(AW), .PAD_BYTE(PAD)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .flush_done(flush_done),
    .addr_load(addr_load), .addr_load_value(addr_load_value),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_rwn(mem_rwn),
    .mem_start(mem_start), .mem_ready(mem_ready), .word_ptr(word_ptr), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: accepted-but-unwritten bytes plus the in-flight write.
  logic [7:0]    q_m[$];
  logic          busy_m;
  logic          pend_m;
  logic          fd_m;
  logic [AW-1:0] ptr_m;
  logic [AW-1:0] addr_m;
  logic [31:0]   data_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    busy_m = 1'b0; pend_m = 1'b0; fd_m = 1'b0;
    ptr_m = '0; addr_m = '0; data_m = 32'd0;
  endtask

  task automatic model_step(input logic iv, input logic [7:0] ib, input logic fl,
                            input logic al, input logic [7:0] alv, input logic mr);
    logic        nfd;
    logic [31:0] w;
    nfd = 1'b0;
    if (busy_m) begin
      if (mr) begin
        ptr_m  = ptr_m + 8'd1;
        busy_m = 1'b0;
        nfd    = pend_m;
        pend_m = 1'b0;
        q_m.delete();
      end
    end else if (al) begin
      ptr_m = alv;
      q_m.delete();
    end else begin
      if (iv) q_m.push_back(ib);
      if (q_m.size() == 4 || (fl && q_m.size() > 0)) begin
        w = 32'd0;
        for (int i = 0; i < 4; i++)
          w = w | (32'((i < q_m.size()) ? q_m[i] : PAD) << (8 * i));
        busy_m = 1'b1;
        pend_m = fl;
        addr_m = ptr_m;
        data_m = w;
      end else if (fl) begin
        nfd = 1'b1;
      end
    end
    fd_m = nfd;
  endtask

  task automatic check_outputs();
    chk("mem_start",   32'(mem_start),   32'(busy_m));
    chk("mem_rwn",     32'(mem_rwn),     32'(!busy_m));
    chk("busy",        32'(busy),        32'(busy_m));
    chk("mem_address", 32'(mem_address), 32'(addr_m));
    chk("mem_data_in", mem_data_in,      data_m);
    chk("word_ptr",    32'(word_ptr),    32'(ptr_m));
    chk("flush_done",  32'(flush_done),  32'(fd_m));
  endtask

  // Called at a falling edge: drive, check ready, clock, advance model, compare.
  task automatic cyc(input logic iv, input logic [7:0] ib, input logic fl,
                     input logic al, input logic [7:0] alv, input logic mr);
    in_valid = iv; in_byte = ib; flush = fl;
    addr_load = al; addr_load_value = alv; mem_ready = mr;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!busy_m && !al));
    @(posedge clk);
    model_step(iv, ib, fl, al, alv, mr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic byte_in(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input logic mr);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, mr);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_byte = 8'h00; flush = 1'b0;
    addr_load = 1'b0; addr_load_value = 8'h00; mem_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outputs();
  endtask

  initial begin
    do_reset();
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst mem_rwn", 32'(mem_rwn), 32'd1);
    chk("rst word_ptr", 32'(word_ptr), 32'd0);

    // Full word, write latency of two cycles.
    byte_in(8'h01); byte_in(8'h02); byte_in(8'h03); byte_in(8'h04);
    chk("w1 data", mem_data_in, 32'h04030201);
    chk("w1 addr", 32'(mem_address), 32'd0);
    chk("w1 rwn", 32'(mem_rwn), 32'd0);
    idle(1'b0);
    idle(1'b1);
    chk("w1 ptr", 32'(word_ptr), 32'd1);
    chk("w1 start drop", 32'(mem_start), 32'd0);

    // Partial flush.
    do_reset();
    byte_in(8'hAA); byte_in(8'hBB);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("fl data", mem_data_in, 32'h0000BBAA);
    chk("fl addr", 32'(mem_address), 32'd0);
    idle(1'b1);
    chk("fl done", 32'(flush_done), 32'd1);
    idle(1'b0);
    chk("fl done one", 32'(flush_done), 32'd0);
    byte_in(8'hCC); byte_in(8'hDD); byte_in(8'hEE); byte_in(8'hFF);
    chk("fl next data", mem_data_in, 32'hFFEEDDCC);
    chk("fl next addr", 32'(mem_address), 32'd1);
    idle(1'b1);

    // Empty flush.
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("ef done", 32'(flush_done), 32'd1);
    chk("ef start", 32'(mem_start), 32'd0);
    idle(1'b0);
    chk("ef done one", 32'(flush_done), 32'd0);

    // Flush together with the fourth byte.
    byte_in(8'h10); byte_in(8'h20); byte_in(8'h30);
    cyc(1'b1, 8'h40, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("f4 data", mem_data_in, 32'h40302010);
    idle(1'b1);
    chk("f4 done", 32'(flush_done), 32'd1);

    // Long write stall with bytes and flush offered.
    byte_in(8'h11); byte_in(8'h22); byte_in(8'h33); byte_in(8'h44);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("stall data", mem_data_in, 32'h44332211);
      chk("stall addr", 32'(mem_address), 32'd3);
    end
    idle(1'b1);
    chk("stall ptr", 32'(word_ptr), 32'd4);
    chk("stall no done", 32'(flush_done), 32'd0);

    // Address load discards a partial word; pointer wraps.
    do_reset();
    byte_in(8'h77); byte_in(8'h88);
    cyc(1'b1, 8'h99, 1'b1, 1'b1, 8'hFF, 1'b0);
    chk("al ptr", 32'(word_ptr), 32'hFF);
    byte_in(8'h01); byte_in(8'h02); byte_in(8'h03); byte_in(8'h04);
    chk("al addr", 32'(mem_address), 32'hFF);
    chk("al data", mem_data_in, 32'h04030201);
    idle(1'b1);
    chk("al wrap", 32'(word_ptr), 32'd0);

    // Reset in the middle of a write.
    byte_in(8'hA1); byte_in(8'hA2); byte_in(8'hA3);
    cyc(1'b1, 8'hA4, 1'b1, 1'b0, 8'h00, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("mr start", 32'(mem_start), 32'd0);
    chk("mr ptr", 32'(word_ptr), 32'd0);
    chk("mr ready", 32'(in_ready), 32'd1);
    chk("mr done", 32'(flush_done), 32'd0);
    do_reset();
    idle(1'b1);
    chk("mr no done", 32'(flush_done), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(0, 9) < 32'd7, 8'($urandom), $urandom_range(0, 9) < 32'd1,
          $urandom_range(0, 19) < 32'd1, 8'($urandom), $urandom_range(0, 9) < 32'd4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
